// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the MIPS run controller.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        RESUME = 2'd2
    } state_t;

    // hz select encoding, slowest to fastest
    localparam logic [1:0] HZ_SLOW = 2'd0;
    localparam logic [1:0] HZ_MID  = 2'd1;
    localparam logic [1:0] HZ_FAST = 2'd2;
    localparam logic [1:0] HZ_FULL = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/core side signals of the run controller, grouped as one bundle.
interface cpu_run_ctrl_if;
    logic        go;
    logic [1:0]  hz;
    logic        halt_req;
    logic        br_taken;
    logic        is_jmp;
    logic        cpu_en;
    logic        clk_n;
    logic        halted;
    logic [31:0] count_all;
    logic [31:0] count_branch;
    logic [31:0] count_jmp;

    modport master (
        output go, hz, halt_req, br_taken, is_jmp,
        input  cpu_en, clk_n, halted, count_all, count_branch, count_jmp
    );

    modport slave (
        input  go, hz, halt_req, br_taken, is_jmp,
        output cpu_en, clk_n, halted, count_all, count_branch, count_jmp
    );
endinterface

// File: rtl/go_debounce.sv
// Go button conditioning: 2-flop synchronizer, stability counter, accepted
// level and a single-cycle pulse on each accepted rising transition.
module go_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic go_i,
    output logic go_pulse_o
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // counter only runs while the synchronized input disagrees with the level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= go_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= level_d & ~level_q;
        end
    end

    assign go_pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: rate divider, RUN/HALT/RESUME sequencing and the
// committed-instruction counters; sole source of the core clock enable.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int DIV_W      = 26,
    parameter int DIV0       = 49_999_999,
    parameter int DIV1       = 4_999_999,
    parameter int DIV2       = 499_999,
    parameter int DIV3       = 0,
    parameter int DEB_CYCLES = 1_000_000
) (
    input logic           clk,
    input logic           clr_n,
    cpu_run_ctrl_if.slave bus
);
    logic [1:0]       hz_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] tc;
    logic             tick;
    logic             go_pulse;
    state_t           state_q;
    state_t           state_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             clk_n_q;
    logic             halted_q;
    logic [31:0]      count_all_q;
    logic [31:0]      count_branch_q;
    logic [31:0]      count_jmp_q;

    go_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_debounce (
        .clk        (clk),
        .clr_n      (clr_n),
        .go_i       (bus.go),
        .go_pulse_o (go_pulse)
    );

    always_comb begin
        case (hz_q)
            HZ_SLOW: tc = DIV_W'(DIV0);
            HZ_MID:  tc = DIV_W'(DIV1);
            HZ_FAST: tc = DIV_W'(DIV2);
            default: tc = DIV_W'(DIV3);
        endcase
    end

    // a rate change restarts the count so the new period starts cleanly
    always_comb begin
        tick      = 1'b0;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (bus.hz != hz_q) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == tc) begin
            tick      = 1'b1;
            div_cnt_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            RUN: begin
                if (tick) begin
                    if (bus.halt_req) state_d  = HALT;
                    else              cpu_en_d = 1'b1;
                end
            end
            HALT: begin
                if (go_pulse) state_d = RESUME;
            end
            RESUME: begin
                // forced step past the syscall (or instruction 0 after reset)
                if (tick) begin
                    cpu_en_d = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hz_q           <= HZ_SLOW;
            div_cnt_q      <= '0;
            state_q        <= HALT;
            cpu_en_q       <= 1'b0;
            clk_n_q        <= 1'b0;
            halted_q       <= 1'b1;
            count_all_q    <= '0;
            count_branch_q <= '0;
            count_jmp_q    <= '0;
        end else begin
            hz_q           <= bus.hz;
            div_cnt_q      <= div_cnt_d;
            state_q        <= state_d;
            cpu_en_q       <= cpu_en_d;
            clk_n_q        <= clk_n_q ^ cpu_en_d;
            halted_q       <= (state_d == HALT);
            // commit happens in the enable cycle, so counters lag cpu_en by one
            count_all_q    <= count_all_q + 32'(cpu_en_q);
            count_branch_q <= count_branch_q + 32'(cpu_en_q & bus.br_taken);
            count_jmp_q    <= count_jmp_q + 32'(cpu_en_q & bus.is_jmp);
        end
    end

    assign bus.cpu_en       = cpu_en_q;
    assign bus.clk_n        = clk_n_q;
    assign bus.halted       = halted_q;
    assign bus.count_all    = count_all_q;
    assign bus.count_branch = count_branch_q;
    assign bus.count_jmp    = count_jmp_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the single-cycle MIPS core on the FPGA board. It is the only source of the core's clock enable. It divides `clk` to the rate selected by `hz`, and holds the core on a halt (syscall) instruction until a debounced `go` press. It also maintains the executed-instruction, taken-branch and jump counters that the display multiplexer shows.

## Interface
Parameters:
- `DIV_W`, 26: width of the rate divider counter.
- `DIV0`, 49_999_999: terminal count for `hz`=0 (slowest rate).
- `DIV1`, 4_999_999: terminal count for `hz`=1.
- `DIV2`, 499_999: terminal count for `hz`=2.
- `DIV3`, 0: terminal count for `hz`=3 (one enable every clock).
- `DEB_CYCLES`, 1_000_000: number of stable cycles needed to accept a `go` level.

Ports:
- `clk`, in, 1: system clock.
- `clr_n`, in, 1: asynchronous, active-low reset.
- `go`, in, 1: raw Go push-button, asynchronous.
- `hz`, in, 2: rate select.
- `halt_req`, in, 1: the core's current instruction is a halt syscall (combinational from decode).
- `br_taken`, in, 1: the current instruction is a taken branch.
- `is_jmp`, in, 1: the current instruction is j, jal or jr.
- `cpu_en`, out, 1: one-cycle enable; the core commits one instruction per pulse.
- `clk_n`, out, 1: toggles on every `cpu_en`; drives the board LED.
- `halted`, out, 1: high while in state HALT.
- `count_all`, out, 32: number of committed instructions.
- `count_branch`, out, 32: number of committed taken branches.
- `count_jmp`, out, 32: number of committed jumps.

## Operation
- **Divider**
  - `div_cnt` counts 0..TC(`hz_q`), where `hz_q` is `hz` registered.
  - At `div_cnt`==TC: `tick`=1 and `div_cnt` returns to 0.
  - If `hz`!=`hz_q`: `div_cnt` is cleared and there is no tick that cycle.
- **go path**
  - 2-flop synchronizer feeds the `go_debounce` sub-module.
  - The accepted level changes only after the synchronized input has been stable for `DEB_CYCLES` consecutive cycles.
  - `go_pulse` is one cycle on each accepted 0->1 transition. Holding the button produces exactly one pulse.
- **State machine**
  - Reset state: HALT.
  - RUN: on a tick with `halt_req`=0, assert `cpu_en`. On a tick with `halt_req`=1, do not assert `cpu_en`; go to HALT (the PC holds on the syscall).
  - HALT: ignore ticks. On `go_pulse`, go to RESUME.
  - RESUME: on the next tick, assert `cpu_en` regardless of `halt_req` (this steps past the syscall, or executes instruction 0 after reset), then go to RUN.
  - `go_pulse` in RUN or RESUME is ignored.
- **Counters** (updated only in the cycle where `cpu_en`=1)
  - `count_all` += 1.
  - `count_branch` += `br_taken`.
  - `count_jmp` += `is_jmp`.
  - All counters wrap modulo 2^32 with no saturation.

## Timing
- All outputs are registered. Reset values: `cpu_en`=0, `clk_n`=0, `halted`=1, all counters 0, `div_cnt`=0, debounced level 0.
- `cpu_en` is high in the cycle after the tick. The counters update on the same edge that drops `cpu_en`, so they are valid one cycle after the pulse.
- Enable period is TC+1 cycles. `DIV3`=0 gives continuous `cpu_en` in RUN.
- `go` edge to `go_pulse`: 2 (sync) + `DEB_CYCLES` cycles. `go_pulse` to leaving HALT: 1 cycle.
- Simultaneous events:
  - `go_pulse` and a tick in HALT: the tick is discarded; the first enable comes on the next tick.
  - `hz` change during RESUME: the counter restarts; the forced enable waits for the new TC.
- Asserting `clr_n` low mid-operation: all state returns to reset values immediately (asynchronously). A pending `cpu_en` pulse is aborted.

## Structure
- Package `cpu_run_pkg` holds:
  - the state enum: RUN=2'd0, HALT=2'd1, RESUME=2'd2;
  - the `hz` encoding constants.
- Sub-module `go_debounce` contains the synchronizer, stable counter, accepted level and rising-edge pulse. It is parameterized by `DEB_CYCLES`.
- The top of `cpu_run_ctrl` contains the divider, FSM and counters.

## Test plan
Bench parameters: `DIV0`=7, `DIV1`=3, `DIV2`=1, `DIV3`=0, `DEB_CYCLES`=4.

1. **Reset and start.** Reset, `hz`=1, no `go` for 40 cycles -> `cpu_en` never asserts, `halted`=1, counters 0. Then press `go` for 10 cycles -> exactly one `go_pulse`; `halted` falls; `cpu_en` then pulses every 4 cycles.
2. **Rates and counting.** In RUN with `hz`=0, `halt_req`=0, count 5 pulses -> spacing 8 cycles and `count_all`=5. Switch to `hz`=3 -> `cpu_en` high every cycle after a 1-cycle gap.
3. **Halt and resume.** `halt_req`=1 at the 3rd tick -> no enable, `halted`=1, `count_all`=2. Hold `halt_req`=1 and press `go` -> exactly one forced `cpu_en`, `count_all`=3, state RUN. At the next tick with `halt_req` still 1 -> HALT again.
4. **Bounce rejection.** `go` toggles every 2 cycles for 20 cycles -> no `go_pulse`. A clean press held 6 cycles -> one pulse.
5. **Event counters.** 6 enables with `br_taken` on enables 2 and 5 and `is_jmp` on enable 4 -> `count_branch`=2, `count_jmp`=1, `count_all`=6. Preload `count_all` to 32'hFFFFFFFF via `force` and give one enable -> `count_all`=0.
6. **Reset mid-operation.** Pulse `clr_n` low for 1 cycle mid-RUN at `hz`=3 -> `cpu_en` drops to 0 immediately, `halted`=1, counters 0, `clk_n`=0.
